// File: rtl/cl_worker_input_loader_pkg.sv
// rtl/cl_worker_input_loader_pkg.sv - shared stream/job types and BRAM sizing helpers
package cl_worker_input_loader_pkg;

    localparam int BRAM_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        STORE_R = 3'd0,
        STORE_Q = 3'd1,
        STORE_I = 3'd2,
        STORE_D = 3'd3,
        STORE_C = 3'd4,
        STORE_H = 3'd5
    } stream_type_t;

    typedef struct packed {
        logic [7:0]  job_id;
        logic [11:0] read_len;
        logic [11:0] hap_len;
    } work_request_2_t;

    // Four 8-bit bases/qualities are packed per BRAM word.
    function automatic int bram_addr_width(input int max_len);
        return $clog2(max_len / 4);
    endfunction

endpackage

// File: rtl/cl_stream_addr_gen.sv
// rtl/cl_stream_addr_gen.sv - per-type BRAM word address generator with saturation and overflow
module cl_stream_addr_gen
    import cl_worker_input_loader_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              beat,
    input  logic              from_idle,
    input  stream_type_t      stream_type,
    input  logic              clear_ovf,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    logic [ADDR_W-1:0] addr_cnt;
    stream_type_t      last_type;
    logic              full;
    logic              restart;

    assign restart = from_idle || (stream_type != last_type);
    assign wr_addr = restart ? '0 : addr_cnt;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            addr_cnt  <= '0;
            last_type <= STORE_R;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (clear_ovf)
                overflow <= 1'b0;
            if (beat) begin
                last_type <= stream_type;
                if (restart) begin
                    addr_cnt <= ADDR_W'(1);
                    full     <= 1'b0;
                end else if (full) begin
                    // Top word already written once: this beat rewrites it and is lost data.
                    overflow <= 1'b1;
                end else if (addr_cnt == TOP_ADDR) begin
                    full <= 1'b1;
                end else begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cl_worker_input_loader.sv
// rtl/cl_worker_input_loader.sv - worker front end: stream capture to BRAM, job latch and handoff
module cl_worker_input_loader
    import cl_worker_input_loader_pkg::*;
#(
    parameter int WORKER_ID           = 0,
    parameter int MAX_SEQUENCE_LENGTH = 2048,
    parameter int BRAM_WORD_W         = BRAM_WORD_WIDTH,
    parameter int BRAM_ADDR_WIDTH     = bram_addr_width(MAX_SEQUENCE_LENGTH)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [BRAM_WORD_W-1:0]     stream_in_tdata,
    input  logic                       stream_in_tvalid,
    input  stream_type_t               stream_type_i,
    input  work_request_2_t            request_i,
    input  logic [7:0]                 selected_worker_i,
    input  logic                       start_i,
    output logic                       ready_o,
    output logic                       bram_wr_en_o,
    output stream_type_t               bram_wr_type_o,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr_o,
    output logic [BRAM_WORD_W-1:0]     bram_wr_data_o,
    output logic                       job_valid_o,
    output work_request_2_t            job_o,
    input  logic                       job_ready_i,
    input  logic                       compute_done_i,
    output logic                       overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_HANDOFF = 2'd2,
        ST_COMPUTE = 2'd3
    } state_t;

    state_t                     state;
    logic                       sel;
    logic                       accepting;
    logic                       beat;
    logic                       start_acc;
    logic [BRAM_ADDR_WIDTH-1:0] gen_addr;

    assign sel       = (selected_worker_i == 8'(WORKER_ID));
    assign accepting = (state == ST_IDLE) || (state == ST_LOADING);
    assign beat      = sel && stream_in_tvalid && accepting;
    assign start_acc = sel && start_i && accepting;

    cl_stream_addr_gen #(
        .ADDR_W(BRAM_ADDR_WIDTH)
    ) u_addr_gen (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .beat        (beat),
        .from_idle   (state == ST_IDLE),
        .stream_type (stream_type_i),
        .clear_ovf   (start_acc),
        .wr_addr     (gen_addr),
        .overflow    (overflow_o)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state          <= ST_IDLE;
            ready_o        <= 1'b1;
            bram_wr_en_o   <= 1'b0;
            bram_wr_type_o <= STORE_R;
            bram_wr_addr_o <= '0;
            bram_wr_data_o <= '0;
            job_valid_o    <= 1'b0;
            job_o          <= '0;
        end else begin
            bram_wr_en_o <= beat;
            if (beat) begin
                bram_wr_type_o <= stream_type_i;
                bram_wr_addr_o <= gen_addr;
                bram_wr_data_o <= stream_in_tdata;
            end

            // A beat coinciding with start is still written above before handing off.
            case (state)
                ST_IDLE, ST_LOADING: begin
                    if (start_acc) begin
                        state       <= ST_HANDOFF;
                        ready_o     <= 1'b0;
                        job_valid_o <= 1'b1;
                        job_o       <= request_i;
                    end else if (beat) begin
                        state <= ST_LOADING;
                    end
                end
                ST_HANDOFF: begin
                    if (job_ready_i) begin
                        state       <= ST_COMPUTE;
                        job_valid_o <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    if (compute_done_i) begin
                        state   <= ST_IDLE;
                        ready_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_worker_input_loader.sv
// tb/tb_cl_worker_input_loader.sv - randomized self-checking bench with behavioural loader model
module tb_cl_worker_input_loader;
    import cl_worker_input_loader_pkg::*;

    localparam int DEPTH_A = 512;
    localparam int DEPTH_B = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [31:0]     tdata;
    logic            tvalid;
    stream_type_t    stype;
    work_request_2_t req;
    logic [7:0]      selw;
    logic            start;
    logic            job_ready;
    logic            done;

    logic            ready_a, en_a, jv_a, ovf_a;
    stream_type_t    type_a;
    logic [8:0]      addr_a;
    logic [31:0]     data_a;
    work_request_2_t job_a;

    logic            ready_b, en_b, jv_b, ovf_b;
    stream_type_t    type_b;
    logic [3:0]      addr_b;
    logic [31:0]     data_b;
    work_request_2_t job_b;

    always #5 clk = ~clk;

    cl_worker_input_loader #(.WORKER_ID(3), .MAX_SEQUENCE_LENGTH(2048)) dut_a (
        .clock_i(clk), .reset_i(rstn), .stream_in_tdata(tdata), .stream_in_tvalid(tvalid),
        .stream_type_i(stype), .request_i(req), .selected_worker_i(selw), .start_i(start),
        .ready_o(ready_a), .bram_wr_en_o(en_a), .bram_wr_type_o(type_a), .bram_wr_addr_o(addr_a),
        .bram_wr_data_o(data_a), .job_valid_o(jv_a), .job_o(job_a), .job_ready_i(job_ready),
        .compute_done_i(done), .overflow_o(ovf_a));

    cl_worker_input_loader #(.WORKER_ID(3), .MAX_SEQUENCE_LENGTH(64)) dut_b (
        .clock_i(clk), .reset_i(rstn), .stream_in_tdata(tdata), .stream_in_tvalid(tvalid),
        .stream_type_i(stype), .request_i(req), .selected_worker_i(selw), .start_i(start),
        .ready_o(ready_b), .bram_wr_en_o(en_b), .bram_wr_type_o(type_b), .bram_wr_addr_o(addr_b),
        .bram_wr_data_o(data_b), .job_valid_o(jv_b), .job_o(job_b), .job_ready_i(job_ready),
        .compute_done_i(done), .overflow_o(ovf_b));

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 loading, 2 handoff, 3 compute
    int              m_state;
    int              m_run_len;
    stream_type_t    m_run_type;
    logic            m_ovf_a, m_ovf_b;
    work_request_2_t m_job;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run_len = 0; m_run_type = STORE_R;
        m_ovf_a = 0; m_ovf_b = 0; m_job = '0;
    endtask

    task automatic do_reset();
        rstn = 0; tvalid = 0; start = 0; job_ready = 0; done = 0; selw = 8'd0;
        tdata = '0; stype = STORE_R; req = '0;
        @(posedge clk); #1;
        model_reset();
        check("rst_ready", {ready_a, ready_b}, 2'b11);
        check("rst_en", {en_a, en_b}, 2'b00);
        check("rst_addr", {addr_a, addr_b}, '0);
        check("rst_type", {type_a, type_b}, '0);
        check("rst_data", {data_a, data_b}, '0);
        check("rst_jv", {jv_a, jv_b}, 2'b00);
        check("rst_job", {job_a, job_b}, '0);
        check("rst_ovf", {ovf_a, ovf_b}, 2'b00);
        rstn = 1;
    endtask

    // Applies one cycle of inputs, advances the model, then checks both instances.
    task automatic step(input logic [7:0] s, input logic v, input stream_type_t t, input logic [31:0] d,
                        input logic st, input work_request_2_t r, input logic jr, input logic dn);
        bit   acc, beat_ok, start_ok, exp_en;
        int   k;
        int   exp_addr_a, exp_addr_b;
        selw = s; tvalid = v; stype = t; tdata = d; start = st; req = r; job_ready = jr; done = dn;
        acc      = (m_state == 0) || (m_state == 1);
        beat_ok  = (s == 8'd3) && v && acc;
        start_ok = (s == 8'd3) && st && acc;
        exp_en = beat_ok;
        exp_addr_a = 0; exp_addr_b = 0;
        if (start_ok) begin m_ovf_a = 0; m_ovf_b = 0; m_job = r; end
        if (beat_ok) begin
            k = (m_state == 0 || t != m_run_type) ? 0 : m_run_len;
            m_run_len  = k + 1;
            m_run_type = t;
            exp_addr_a = (k < DEPTH_A) ? k : DEPTH_A - 1;
            exp_addr_b = (k < DEPTH_B) ? k : DEPTH_B - 1;
            if (k >= DEPTH_A) m_ovf_a = 1;
            if (k >= DEPTH_B) m_ovf_b = 1;
        end
        case (m_state)
            0: if (start_ok) m_state = 2; else if (beat_ok) m_state = 1;
            1: if (start_ok) m_state = 2;
            2: if (jr) m_state = 3;
            default: if (dn) m_state = 0;
        endcase
        @(posedge clk); #1;
        check("ready", {ready_a, ready_b}, {2{m_state < 2}});
        check("wr_en", {en_a, en_b}, {2{exp_en}});
        if (exp_en) begin
            check("addr_a", addr_a, exp_addr_a);
            check("addr_b", addr_b, exp_addr_b);
            check("wr_type", {type_a, type_b}, {t, t});
            check("wr_data", {data_a, data_b}, {d, d});
        end
        check("job_valid", {jv_a, jv_b}, {2{m_state == 2}});
        if (m_state == 2) check("job", {job_a, job_b}, {m_job, m_job});
        check("ovf_a", ovf_a, m_ovf_a);
        check("ovf_b", ovf_b, m_ovf_b);
    endtask

    task automatic idle_cycle();
        step(8'd3, 0, STORE_R, '0, 0, '0, 0, 0);
    endtask

    task automatic run_job(input work_request_2_t r, input int wait_cycles);
        step(8'd3, 0, STORE_R, '0, 1, r, 0, 0);
        for (int i = 0; i < wait_cycles; i++) step(8'd3, 0, STORE_R, '0, 0, '0, 0, 0);
        step(8'd3, 0, STORE_R, '0, 0, '0, 1, 0);
        step(8'd3, 0, STORE_R, '0, 0, '0, 0, 0);
        step(8'd3, 0, STORE_R, '0, 0, '0, 0, 1);
    endtask

    initial begin
        work_request_2_t r;
        do_reset();

        // 32 R beats: A fills 0..31, B saturates at 15 and flags overflow
        for (int i = 0; i < 32; i++) step(8'd3, 1, STORE_R, i, 0, '0, 0, 0);
        run_job(32'h0A01_2345, 2);

        // R x16, Q x16, H x32 then start
        for (int i = 0; i < 16; i++) step(8'd3, 1, STORE_R, $urandom, 0, '0, 0, 0);
        for (int i = 0; i < 16; i++) step(8'd3, 1, STORE_Q, $urandom, 0, '0, 0, 0);
        for (int i = 0; i < 32; i++) step(8'd3, 1, STORE_H, $urandom, 0, '0, 0, 0);
        run_job(32'h1234_5678, 0);

        // other worker selected: everything ignored
        for (int i = 0; i < 8; i++) step(8'd2, 1, STORE_I, $urandom, i == 4, '0, 0, 0);

        // 18 R beats: B overflows, next start clears it
        for (int i = 0; i < 18; i++) step(8'd3, 1, STORE_R, 32'hB000 + i, 0, '0, 0, 0);
        idle_cycle();
        run_job(32'hCAFE_0042, 5);

        // reset mid-loading, then first beat must go to address 0
        for (int i = 0; i < 8; i++) step(8'd3, 1, STORE_D, i, 0, '0, 0, 0);
        do_reset();
        step(8'd3, 1, STORE_D, 32'hD00D, 0, '0, 0, 0);
        step(8'd3, 1, STORE_D, 32'hD00E, 0, '0, 0, 0);
        idle_cycle();
        run_job(32'h0, 1);

        // randomized traffic, types biased toward long runs
        for (int i = 0; i < 1500; i++) begin
            stream_type_t t;
            t = stream_type_t'($urandom_range(0, 5));
            if ($urandom_range(0, 7) != 0) t = m_run_type;
            r = work_request_2_t'($urandom);
            step(($urandom_range(0, 5) == 0) ? 8'd2 : 8'd3, $urandom_range(0, 3) != 0, t, $urandom,
                 $urandom_range(0, 40) == 0, r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
